// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Optional build macro ARB_TIMEOUT_EN adds a mem_ready watchdog and sticky bus_err.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 63
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_done,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_done,
  output logic [DW-1:0]   d_rdata,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            mem_valid,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata,
  output logic            bus_err
);

  localparam int         BW         = DW / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic            own_d_q;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [DW-1:0]   wdata_q;
  logic [BW-1:0]   be_q;
  logic [DW-1:0]   i_rdata_q;
  logic [DW-1:0]   d_rdata_q;
  logic [3:0]      starve_q;
  logic            grant_i;
  logic            grant_d;
  logic            complete;
  logic            busy;

  assign busy = (state_q == IBUSY) || (state_q == DBUSY);

`ifdef ARB_TIMEOUT_EN
  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_q;
  logic              bus_err_q;
  logic              abort;
`endif

  always_comb begin
    state_d  = state_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    complete = 1'b0;
`ifdef ARB_TIMEOUT_EN
    abort    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // Data wins unless fetch has already been passed over STARVE_MAX times.
        if (d_req && !(i_req && (starve_q == STARVE_LIM))) begin
          grant_d = 1'b1;
          state_d = DBUSY;
        end else if (i_req) begin
          grant_i = 1'b1;
          state_d = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (mem_ready) begin
          complete = 1'b1;
          state_d  = DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          abort   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request is captured at grant so the memory side never sees requester churn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      own_d_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        own_d_q <= 1'b1;
        addr_q  <= d_addr;
        we_q    <= d_we;
        wdata_q <= d_we ? d_wdata : '0;
        be_q    <= d_we ? d_be : '0;
      end else if (grant_i) begin
        own_d_q <= 1'b0;
        addr_q  <= i_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
        be_q    <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (complete && (state_q == IBUSY)) i_rdata_q <= mem_rdata;
      if (complete && (state_q == DBUSY) && !we_q) d_rdata_q <= mem_rdata;
`ifdef ARB_TIMEOUT_EN
      if (abort && (state_q == IBUSY)) i_rdata_q <= '0;
      if (abort && (state_q == DBUSY)) d_rdata_q <= '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (grant_d && i_req) begin
      if (starve_q != STARVE_LIM) starve_q <= starve_q + 4'd1;
    end else if (grant_i || ((state_q == IDLE) && !i_req)) begin
      starve_q <= '0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (grant_d || grant_i) wait_q <= '0;
      else if (busy)          wait_q <= wait_q + WAIT_W'(1);
      if (abort) bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign bus_err        = 1'b0;
`endif

  assign mem_valid = busy;
  assign mem_we    = busy & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  assign i_done    = (state_q == DONE) && !own_d_q;
  assign d_done    = (state_q == DONE) && own_d_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign stall_if  = i_req & ~i_done;
  assign stall_mem = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a wait-state memory responder checks each
// access in grant order and a done monitor checks owner and returned data.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic          i_done, d_done;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          stall_if, stall_mem;
  logic          mem_valid, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0] mem_be;
  logic          bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4), .TIMEOUT(63)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } acc_t;

  typedef struct {
    logic          is_d;
    logic [DW-1:0] rdata;
  } done_t;

  acc_t          acc_q[$];
  done_t         done_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            wait_cfg = 0;
  int            wcnt = 0;
  logic          spurious_ready = 1'b0;
  logic [DW-1:0] pred_d_rd = '0;

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_f(input logic [AW-1:0] a);
    acc_q.push_back('{we: 1'b0, addr: a, wdata: '0, be: '0});
    done_q.push_back('{is_d: 1'b0, rdata: rd_model(a)});
  endtask

  task automatic push_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [BW-1:0] be);
    acc_q.push_back('{we: we, addr: a, wdata: wd, be: be});
    if (!we) pred_d_rd = rd_model(a);
    done_q.push_back('{is_d: 1'b1, rdata: pred_d_rd});
  endtask

  // Memory model: answers after wait_cfg low cycles, checks the presented request each cycle.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      mem_ready = 1'b0;
      wcnt      = 0;
    end else if (mem_valid) begin
      if (acc_q.size() == 0) begin
        chk("unexpected_access", 1, 0);
        mem_ready = 1'b1;
      end else begin
        chk("mem_addr", mem_addr, acc_q[0].addr);
        chk("mem_we", mem_we, acc_q[0].we);
        if (acc_q[0].we) begin
          chk("mem_wdata", mem_wdata, acc_q[0].wdata);
          chk("mem_be", mem_be, acc_q[0].be);
        end
        if (wcnt >= wait_cfg) begin
          mem_ready = 1'b1;
          mem_rdata = rd_model(acc_q[0].addr);
          void'(acc_q.pop_front());
          wcnt = 0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'hCAFE_F00D;
          wcnt++;
        end
      end
    end else begin
      mem_ready = spurious_ready;
      mem_rdata = 32'h0BAD_F00D;
      wcnt      = 0;
    end
  end

  always @(negedge clk) begin
    if ((reset === 1'b1) && (i_done || d_done)) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        done_t e;
        e = done_q.pop_front();
        chk("done_owner", {i_done, d_done}, {~e.is_d, e.is_d});
        chk("done_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
      end
    end
  end

  task automatic run_fetch(input logic [AW-1:0] base, input int n, input int exp_lat);
    int lat;
    @(posedge clk); #1;
    i_req  = 1'b1;
    i_addr = base;
    for (int k = 0; k < n; k++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        if (exp_lat != 0) chk("stall_if", stall_if, lat < exp_lat);
      end while (!i_done && lat < 200);
      if (!i_done) chk("i_done_hang", 0, 1);
      else if (exp_lat != 0) chk("i_latency", lat, exp_lat);
      @(posedge clk); #1;
      if (k == n - 1) i_req = 1'b0;
      else i_addr = base + 32'(4 * (k + 1));
    end
  endtask

  task automatic run_data(input logic we, input logic [AW-1:0] base, input logic [DW-1:0] wd,
                          input logic [BW-1:0] be, input int n, input int exp_lat);
    int lat;
    @(posedge clk); #1;
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = base;
    d_wdata = wd;
    d_be    = be;
    for (int k = 0; k < n; k++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        if (exp_lat != 0) chk("stall_mem", stall_mem, lat < exp_lat);
      end while (!d_done && lat < 200);
      if (!d_done) chk("d_done_hang", 0, 1);
      else if (exp_lat != 0) chk("d_latency", lat, exp_lat);
      @(posedge clk); #1;
      if (k == n - 1) d_req = 1'b0;
      else d_addr = base + 32'(4 * (k + 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_i_done", i_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    reset = 1'b1;

    // Fetch only, zero wait states.
    push_f(32'h100);
    run_fetch(32'h100, 1, 3);

    // Simultaneous store and fetch: data first, fetch three cycles later.
    push_d(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011);
    push_f(32'h104);
    fork
      run_data(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 1, 3);
      run_fetch(32'h104, 1, 6);
    join

    // Starvation: four data grants, then fetch; counter restarts for the second fetch.
    for (int k = 0; k < 4; k++) push_d(1'b0, 32'h4000 + 32'(4 * k), '0, '0);
    push_f(32'h500);
    for (int k = 4; k < 8; k++) push_d(1'b0, 32'h4000 + 32'(4 * k), '0, '0);
    push_f(32'h504);
    push_d(1'b0, 32'h4020, '0, '0);
    fork
      run_data(1'b0, 32'h4000, '0, '0, 9, 0);
      run_fetch(32'h500, 2, 0);
    join

    // Five wait states with the requester address changing underneath.
    wait_cfg = 5;
    push_d(1'b0, 32'h6000, '0, '0);
    fork
      run_data(1'b0, 32'h6000, '0, '0, 1, 8);
      begin
        repeat (3) @(posedge clk);
        #2 d_addr = 32'hFFFF_0000;
      end
    join
    wait_cfg = 0;

    // mem_ready while idle must not start or complete anything.
    spurious_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("spurious_valid", mem_valid, 0);
      chk("spurious_done", {i_done, d_done}, 2'b00);
    end
    spurious_ready = 1'b0;

    // Reset asserted while a load is in flight.
    wait_cfg = 20;
    acc_q.push_back('{we: 1'b0, addr: 32'h3000, wdata: '0, be: '0});
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", mem_valid, 1);
    #2 reset = 1'b0;
    #1 chk("rst_async_valid", mem_valid, 0);
    @(posedge clk); #1;
    d_req = 1'b0;
    acc_q.delete();
    wait_cfg = 0;
    pred_d_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst2_d_done", d_done, 0);
    chk("rst2_i_rdata", i_rdata, 0);
    chk("rst2_d_rdata", d_rdata, 0);
    reset = 1'b1;
    push_d(1'b0, 32'h3004, '0, '0);
    run_data(1'b0, 32'h3004, '0, '0, 1, 3);
    push_f(32'h108);
    run_fetch(32'h108, 1, 3);

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: abort after 63 wait cycles with zeroed data.
    wait_cfg = 1000;
    acc_q.push_back('{we: 1'b0, addr: 32'h7000, wdata: '0, be: '0});
    pred_d_rd = '0;
    done_q.push_back('{is_d: 1'b1, rdata: '0});
    run_data(1'b0, 32'h7000, '0, '0, 1, 65);
    acc_q.delete();
    wait_cfg = 0;
    chk("timeout_bus_err", bus_err, 1);
    push_f(32'h10C);
    run_fetch(32'h10C, 1, 3);
    chk("bus_err_sticky", bus_err, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("bus_err_reset", bus_err, 0);
    reset = 1'b1;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("acc_q_empty", acc_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    chk("final_bus_err", bus_err, 0);
    chk("final_idle", mem_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
